avl_bus_checker: RTL and testbench
==================================

Name: avl_bus_checker

Overview:
Synthesizable, parametrised protocol checker for the Avalon-style bus. It passively monitors MASTER_NUM master ports and tracks outstanding reads per master in a timestamp FIFO. It flags protocol violations (overflow, orphan response, timeout, request-hold breach, read/write conflict, multi-issue) and measures worst-case read latency per master. It sits beside the bus interconnect in both simulation and FPGA builds, and its error outputs feed the debug CSR block.

Parameters:
MASTER_NUM, 8, number of monitored master ports
DEPTH, 4, maximum outstanding reads per master (power of 2, >=2)
TS_W, 16, width of timestamp and latency values
TIMEOUT, 1024, cycles a read may stay outstanding before timeout (1..2^TS_W-1)
SINGLE_ISSUE, 1, 1 = more than one accepted command per cycle is an error
CNT_W, 16, width of the error event counter

Ports:
clk  in  1  clock
rest  in  1  reset, synchronous, active-high
clear  in  1  synchronous clear of flags, counter and max latency
mon_read  in  MASTER_NUM  read request per master
mon_write  in  MASTER_NUM  write request per master
mon_request_ready  in  MASTER_NUM  slave accepts request
mon_address  in  32*MASTER_NUM  request address, master i at [32i+31:32i]
mon_byte_en  in  4*MASTER_NUM  byte enables, master i at [4i+3:4i]
mon_read_data_valid  in  MASTER_NUM  read response valid
mon_resp_ready  in  MASTER_NUM  master accepts response
err_flags  out  5*MASTER_NUM  sticky per-master flags {conflict,hold,timeout,underflow,overflow}
err_multi  out  1  sticky multi-issue flag
err_count  out  CNT_W  saturating count of error-event cycles
outstanding  out  (clog2(DEPTH)+1)*MASTER_NUM  current outstanding reads per master
max_latency  out  TS_W*MASTER_NUM  worst read latency per master

Behaviour:
- Reset (rest=1 at clk edge): all outputs 0, FIFOs empty, timestamp counter 0, hold-tracking registers cleared. Reset mid-transaction discards all outstanding entries without raising errors.
- now: free-running TS_W counter, +1 every cycle, wraps modulo 2^TS_W. All latency arithmetic is modulo 2^TS_W.
- acc_rd[i] = read & request_ready. acc_wr[i] = write & request_ready. resp[i] = read_data_valid & resp_ready.
- acc_rd pushes now into master i's FIFO.
- resp pops the FIFO head. lat = now - head_ts. If lat > max_latency[i], max_latency[i] <= lat on the next edge. Minimum legal lat is 1.
- Push and pop in the same cycle with a non-empty FIFO: both happen, occupancy unchanged.
- overflow: acc_rd while occupancy==DEPTH and no pop in the same cycle. The push is dropped.
- underflow: resp while occupancy==0. A same-cycle acc_rd does not satisfy it; the push still occurs.
- timeout: occupancy>0 and (now - head_ts) >= TIMEOUT. The entry stays; the flag is sticky.
- hold: if in the previous cycle (read|write) was high and request_ready was low, then read, write, address and byte_en must be unchanged this cycle, otherwise flag. Write data is not checked.
- conflict: read&write both high in the same cycle, or write high with byte_en==0.
- err_multi: SINGLE_ISSUE=1 and more than one master has acc_rd|acc_wr in the same cycle. When SINGLE_ISSUE=0, err_multi is tied to 0.
- Flags register one cycle after the offending edge and stay set until clear or rest.
- err_count increments by exactly 1 per cycle in which any new error event is detected, however many events occur in that cycle. It saturates at 2^CNT_W-1.
- clear: zeros err_flags, err_multi, err_count and max_latency. It does not touch FIFOs or now. If clear and an error event coincide, clear wins for that cycle.
- outstanding[i] reflects registered FIFO occupancy. It updates one cycle after a push or pop.

Test Plan:
- Master 0 issues read at t, response at t+5 -> outstanding 1 then 0, max_latency[0]=5, no flags, err_count=0.
- Master 2 issues 5 reads with DEPTH=4 and no responses -> err_flags[2].overflow=1, outstanding[2]=4, err_count=1.
- Response on master 1 with nothing outstanding, same cycle as an accepted read -> underflow=1, outstanding[1]=1.
- Read held with TIMEOUT=8 and no response -> timeout set 8 cycles after acceptance, one count increment, entry still present.
- Master 3 changes address while request_ready=0 -> hold=1. Master 4 writes with byte_en=0 -> conflict=1. Both in the same cycle -> err_count +1 only.
- Masters 0 and 5 accepted in the same cycle -> err_multi=1. Then pulse clear -> all flags, err_count and max_latency read 0, outstanding unchanged.

Source files
------------

// File: rtl/avl_bus_checker.sv
// rtl/avl_bus_checker.sv - passive Avalon-style bus protocol checker with read latency tracking
module avl_bus_checker #(
    parameter int MASTER_NUM   = 8,
    parameter int DEPTH        = 4,
    parameter int TS_W         = 16,
    parameter int TIMEOUT      = 1024,
    parameter int SINGLE_ISSUE = 1,
    parameter int CNT_W        = 16
) (
    input  logic                                     clk,
    input  logic                                     rest,
    input  logic                                     clear,
    input  logic [MASTER_NUM-1:0]                    mon_read,
    input  logic [MASTER_NUM-1:0]                    mon_write,
    input  logic [MASTER_NUM-1:0]                    mon_request_ready,
    input  logic [32*MASTER_NUM-1:0]                 mon_address,
    input  logic [4*MASTER_NUM-1:0]                  mon_byte_en,
    input  logic [MASTER_NUM-1:0]                    mon_read_data_valid,
    input  logic [MASTER_NUM-1:0]                    mon_resp_ready,
    output logic [5*MASTER_NUM-1:0]                  err_flags,
    output logic                                     err_multi,
    output logic [CNT_W-1:0]                         err_count,
    output logic [($clog2(DEPTH)+1)*MASTER_NUM-1:0]  outstanding,
    output logic [TS_W*MASTER_NUM-1:0]               max_latency
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [TS_W-1:0]  TIMEOUT_TS = TS_W'(TIMEOUT);
    localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(DEPTH);

    // Free-running timestamp; all ages are computed modulo 2^TS_W
    logic [TS_W-1:0] now;

    // Accepted commands and accepted responses per master
    logic [MASTER_NUM-1:0] acc_rd;
    logic [MASTER_NUM-1:0] acc_wr;
    logic [MASTER_NUM-1:0] resp;
    logic [MASTER_NUM-1:0] issued;

    // Error events detected in the current cycle, before registering
    logic [MASTER_NUM-1:0] ev_ovf;
    logic [MASTER_NUM-1:0] ev_udf;
    logic [MASTER_NUM-1:0] ev_tmo;
    logic [MASTER_NUM-1:0] ev_hold;
    logic [MASTER_NUM-1:0] ev_conf;
    logic                  ev_multi;
    logic                  any_ev;

    assign acc_rd = mon_read & mon_request_ready;
    assign acc_wr = mon_write & mon_request_ready;
    assign resp   = mon_read_data_valid & mon_resp_ready;
    assign issued = acc_rd | acc_wr;

    // Timestamp counter
    always_ff @(posedge clk) begin
        if (rest) begin
            now <= '0;
        end else begin
            now <= now + 1'b1;
        end
    end

    for (genvar i = 0; i < MASTER_NUM; i++) begin : g_master
        logic [TS_W-1:0]  mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [OCC_W-1:0] occ;
        logic [TS_W-1:0]  head_ts;
        logic [TS_W-1:0]  age;
        logic             empty;
        logic             full;
        logic             push;
        logic             pop;
        logic [31:0]      addr;
        logic [3:0]       byte_en;
        logic             prev_pend;
        logic             prev_rd;
        logic             prev_wr;
        logic [31:0]      prev_addr;
        logic [3:0]       prev_be;
        logic [4:0]       flags;
        logic [TS_W-1:0]  max_lat;

        assign addr    = mon_address[32*i +: 32];
        assign byte_en = mon_byte_en[4*i +: 4];

        assign empty   = (occ == '0);
        assign full    = (occ == OCC_FULL);
        assign head_ts = mem[rd_ptr];
        assign age     = now - head_ts;

        // A full FIFO still takes a push when the head leaves in the same cycle
        assign pop  = resp[i] & ~empty;
        assign push = acc_rd[i] & (~full | pop);

        assign ev_ovf[i]  = acc_rd[i] & full & ~pop;
        assign ev_udf[i]  = resp[i] & empty;
        // Timeout is reported once; a stale head keeps the sticky flag instead of recounting
        assign ev_tmo[i]  = ~empty & (age >= TIMEOUT_TS) & ~flags[2];
        assign ev_hold[i] = prev_pend & ((mon_read[i] != prev_rd) |
                                         (mon_write[i] != prev_wr) |
                                         (addr != prev_addr) |
                                         (byte_en != prev_be));
        assign ev_conf[i] = (mon_read[i] & mon_write[i]) |
                            (mon_write[i] & (byte_en == 4'd0));

        // Timestamp storage; contents are meaningless while the slot is unoccupied
        always_ff @(posedge clk) begin
            if (!rest && push) begin
                mem[wr_ptr] <= now;
            end
        end

        // FIFO pointers and occupancy
        always_ff @(posedge clk) begin
            if (rest) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    occ <= occ + 1'b1;
                end else if (pop && !push) begin
                    occ <= occ - 1'b1;
                end
            end
        end

        // Remember a stalled request so the next cycle can verify it was held
        always_ff @(posedge clk) begin
            if (rest) begin
                prev_pend <= 1'b0;
                prev_rd   <= 1'b0;
                prev_wr   <= 1'b0;
                prev_addr <= '0;
                prev_be   <= '0;
            end else begin
                prev_pend <= (mon_read[i] | mon_write[i]) & ~mon_request_ready[i];
                prev_rd   <= mon_read[i];
                prev_wr   <= mon_write[i];
                prev_addr <= addr;
                prev_be   <= byte_en;
            end
        end

        // Sticky per-master flags {conflict,hold,timeout,underflow,overflow}
        always_ff @(posedge clk) begin
            if (rest || clear) begin
                flags <= '0;
            end else begin
                flags <= flags | {ev_conf[i], ev_hold[i], ev_tmo[i], ev_udf[i], ev_ovf[i]};
            end
        end

        // Worst observed read latency
        always_ff @(posedge clk) begin
            if (rest || clear) begin
                max_lat <= '0;
            end else if (pop && (age > max_lat)) begin
                max_lat <= age;
            end
        end

        assign err_flags[5*i +: 5]            = flags;
        assign outstanding[OCC_W*i +: OCC_W]  = occ;
        assign max_latency[TS_W*i +: TS_W]    = max_lat;
    end

    // More than one set bit in the issue vector means concurrent acceptance
    assign ev_multi = (SINGLE_ISSUE != 0) && ((issued & (issued - 1'b1)) != '0);

    assign any_ev = (|ev_ovf) | (|ev_udf) | (|ev_tmo) | (|ev_hold) | (|ev_conf) | ev_multi;

    // Sticky multi-issue flag
    always_ff @(posedge clk) begin
        if (rest || clear) begin
            err_multi <= 1'b0;
        end else if (ev_multi) begin
            err_multi <= 1'b1;
        end
    end

    // Saturating count of cycles carrying at least one error event
    always_ff @(posedge clk) begin
        if (rest || clear) begin
            err_count <= '0;
        end else if (any_ev && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_avl_bus_checker.sv
// tb/tb_avl_bus_checker.sv - self-checking bench for avl_bus_checker
module tb_avl_bus_checker;

    localparam int MN           = 8;
    localparam int DEPTH        = 4;
    localparam int TS_W         = 16;
    localparam int TIMEOUT      = 8;
    localparam int SINGLE_ISSUE = 1;
    localparam int CNT_W        = 4;
    localparam int OCC_W        = $clog2(DEPTH) + 1;
    localparam int MASK         = (1 << TS_W) - 1;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rest;
    logic clear;
    logic [MN-1:0]        mon_read;
    logic [MN-1:0]        mon_write;
    logic [MN-1:0]        mon_request_ready;
    logic [32*MN-1:0]     mon_address;
    logic [4*MN-1:0]      mon_byte_en;
    logic [MN-1:0]        mon_read_data_valid;
    logic [MN-1:0]        mon_resp_ready;
    logic [5*MN-1:0]      err_flags;
    logic                 err_multi;
    logic [CNT_W-1:0]     err_count;
    logic [OCC_W*MN-1:0]  outstanding;
    logic [TS_W*MN-1:0]   max_latency;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         q [MN][$];
    logic [4:0] m_flags [MN];
    int         m_maxlat [MN];
    bit         m_pend [MN];
    bit         m_prd [MN];
    bit         m_pwr [MN];
    logic [31:0] m_paddr [MN];
    logic [3:0] m_pbe [MN];
    bit         m_multi;
    int         m_count;
    int         m_now;

    always #5 clk = ~clk;

    avl_bus_checker #(
        .MASTER_NUM(MN), .DEPTH(DEPTH), .TS_W(TS_W), .TIMEOUT(TIMEOUT),
        .SINGLE_ISSUE(SINGLE_ISSUE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rest(rest), .clear(clear),
        .mon_read(mon_read), .mon_write(mon_write),
        .mon_request_ready(mon_request_ready),
        .mon_address(mon_address), .mon_byte_en(mon_byte_en),
        .mon_read_data_valid(mon_read_data_valid),
        .mon_resp_ready(mon_resp_ready),
        .err_flags(err_flags), .err_multi(err_multi), .err_count(err_count),
        .outstanding(outstanding), .max_latency(max_latency)
    );

    function automatic int occ_of(input int i);
        return int'(outstanding[OCC_W*i +: OCC_W]);
    endfunction

    function automatic int lat_of(input int i);
        return int'(max_latency[TS_W*i +: TS_W]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MN; i++) begin
            q[i].delete();
            m_flags[i]  = '0;
            m_maxlat[i] = 0;
            m_pend[i]   = 0;
            m_prd[i]    = 0;
            m_pwr[i]    = 0;
            m_paddr[i]  = '0;
            m_pbe[i]    = '0;
        end
        m_multi = 0;
        m_count = 0;
        m_now   = 0;
    endtask

    // Apply the rules to the inputs present this cycle; results become visible after the edge
    task automatic model_cycle();
        int issued;
        bit any;
        if (rest) begin
            model_reset();
            return;
        end
        issued = 0;
        any = 0;
        for (int i = 0; i < MN; i++) begin
            bit rd, wr, rdy, rs, arb, aw;
            logic [31:0] a;
            logic [3:0] b;
            logic [4:0] ev;
            int occ, age;
            rd  = mon_read[i];
            wr  = mon_write[i];
            rdy = mon_request_ready[i];
            rs  = mon_read_data_valid[i] & mon_resp_ready[i];
            a   = mon_address[32*i +: 32];
            b   = mon_byte_en[4*i +: 4];
            arb = rd & rdy;
            aw  = wr & rdy;
            occ = q[i].size();
            if (arb || aw) issued++;
            age = (occ > 0) ? ((m_now - q[i][0]) & MASK) : 0;
            ev = '0;
            ev[0] = arb && (occ == DEPTH) && !rs;
            ev[1] = rs && (occ == 0);
            ev[2] = (occ > 0) && (age >= TIMEOUT) && !m_flags[i][2];
            ev[3] = m_pend[i] && ((rd != m_prd[i]) || (wr != m_pwr[i]) ||
                                  (a != m_paddr[i]) || (b != m_pbe[i]));
            ev[4] = (rd && wr) || (wr && (b == 4'd0));
            if (ev != 0) any = 1;
            if (rs && occ > 0) begin
                void'(q[i].pop_front());
                if (age > m_maxlat[i]) m_maxlat[i] = age;
            end
            if (arb && !ev[0]) q[i].push_back(m_now);
            if (clear) begin
                m_flags[i]  = '0;
                m_maxlat[i] = 0;
            end else begin
                m_flags[i] = m_flags[i] | ev;
            end
            m_pend[i]  = (rd || wr) && !rdy;
            m_prd[i]   = rd;
            m_pwr[i]   = wr;
            m_paddr[i] = a;
            m_pbe[i]   = b;
        end
        if (SINGLE_ISSUE != 0 && issued > 1) any = 1;
        if (clear) begin
            m_multi = 0;
            m_count = 0;
        end else begin
            if (SINGLE_ISSUE != 0 && issued > 1) m_multi = 1;
            if (any && m_count < CNT_MAX) m_count++;
        end
        m_now = (m_now + 1) & MASK;
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear               = 1'b0;
        mon_read            = '0;
        mon_write           = '0;
        mon_request_ready   = '0;
        mon_address         = '0;
        mon_byte_en         = '0;
        mon_read_data_valid = '0;
        mon_resp_ready      = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rest = 1'b1;
        step();
        step();
        rest = 1'b0;
    endtask

    task automatic test_reset();
        mon_read = '1;
        mon_request_ready = '1;
        rest = 1'b1;
        step();
        do_reset();
        checks++; if (err_flags !== '0) begin errors++; $display("FAIL reset_flags got %0h want 0", err_flags); end
        checks++; if (err_multi !== 1'b0) begin errors++; $display("FAIL reset_multi got %0b want 0", err_multi); end
        checks++; if (err_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", err_count); end
        checks++; if (outstanding !== '0) begin errors++; $display("FAIL reset_outstanding got %0h want 0", outstanding); end
        checks++; if (max_latency !== '0) begin errors++; $display("FAIL reset_max_latency got %0h want 0", max_latency); end
    endtask

    task automatic test_read_latency();
        do_reset();
        mon_read[0] = 1'b1;
        mon_request_ready[0] = 1'b1;
        step();
        idle_inputs();
        checks++; if (occ_of(0) !== 1) begin errors++; $display("FAIL lat_outstanding_after_push got %0d want 1", occ_of(0)); end
        repeat (4) step();
        mon_read_data_valid[0] = 1'b1;
        mon_resp_ready[0] = 1'b1;
        step();
        idle_inputs();
        checks++; if (occ_of(0) !== 0) begin errors++; $display("FAIL lat_outstanding_after_pop got %0d want 0", occ_of(0)); end
        checks++; if (lat_of(0) !== 5) begin errors++; $display("FAIL lat_max_latency got %0d want 5", lat_of(0)); end
        checks++; if (err_flags !== '0) begin errors++; $display("FAIL lat_flags got %0h want 0", err_flags); end
        checks++; if (err_count !== '0) begin errors++; $display("FAIL lat_count got %0d want 0", err_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        mon_read[2] = 1'b1;
        mon_request_ready[2] = 1'b1;
        repeat (5) step();
        idle_inputs();
        checks++; if (occ_of(2) !== DEPTH) begin errors++; $display("FAIL ovf_outstanding got %0d want %0d", occ_of(2), DEPTH); end
        checks++; if (err_flags !== (5*MN)'(1) << 10) begin errors++; $display("FAIL ovf_flags got %0h want %0h", err_flags, (5*MN)'(1) << 10); end
        checks++; if (err_count !== 1) begin errors++; $display("FAIL ovf_count got %0d want 1", err_count); end
    endtask

    task automatic test_underflow();
        do_reset();
        mon_read[1] = 1'b1;
        mon_request_ready[1] = 1'b1;
        mon_read_data_valid[1] = 1'b1;
        mon_resp_ready[1] = 1'b1;
        step();
        idle_inputs();
        checks++; if (err_flags !== (5*MN)'(1) << 6) begin errors++; $display("FAIL udf_flags got %0h want %0h", err_flags, (5*MN)'(1) << 6); end
        checks++; if (occ_of(1) !== 1) begin errors++; $display("FAIL udf_outstanding got %0d want 1", occ_of(1)); end
        checks++; if (err_count !== 1) begin errors++; $display("FAIL udf_count got %0d want 1", err_count); end
    endtask

    task automatic test_timeout();
        do_reset();
        mon_read[0] = 1'b1;
        mon_request_ready[0] = 1'b1;
        step();
        idle_inputs();
        repeat (TIMEOUT - 1) step();
        checks++; if (err_flags[2] !== 1'b0) begin errors++; $display("FAIL tmo_early got %0b want 0", err_flags[2]); end
        step();
        checks++; if (err_flags !== (5*MN)'(4)) begin errors++; $display("FAIL tmo_flags got %0h want 4", err_flags); end
        repeat (5) step();
        checks++; if (err_count !== 1) begin errors++; $display("FAIL tmo_count got %0d want 1", err_count); end
        checks++; if (occ_of(0) !== 1) begin errors++; $display("FAIL tmo_outstanding got %0d want 1", occ_of(0)); end
    endtask

    task automatic test_hold_conflict();
        logic [5*MN-1:0] want;
        do_reset();
        mon_read[3] = 1'b1;
        mon_address[32*3 +: 32] = 32'h100;
        mon_byte_en[4*3 +: 4] = 4'hF;
        step();
        mon_address[32*3 +: 32] = 32'h104;
        mon_write[4] = 1'b1;
        mon_request_ready[4] = 1'b1;
        mon_byte_en[4*4 +: 4] = 4'h0;
        step();
        idle_inputs();
        want = ((5*MN)'(1) << 18) | ((5*MN)'(1) << 24);
        checks++; if (err_flags !== want) begin errors++; $display("FAIL hold_conf_flags got %0h want %0h", err_flags, want); end
        checks++; if (err_count !== 1) begin errors++; $display("FAIL hold_conf_count got %0d want 1", err_count); end
    endtask

    task automatic test_multi_clear();
        do_reset();
        mon_read[0] = 1'b1;
        mon_request_ready[0] = 1'b1;
        step();
        idle_inputs();
        repeat (2) step();
        mon_read_data_valid[0] = 1'b1;
        mon_resp_ready[0] = 1'b1;
        step();
        idle_inputs();
        mon_read[0] = 1'b1;
        mon_request_ready[0] = 1'b1;
        mon_write[5] = 1'b1;
        mon_request_ready[5] = 1'b1;
        mon_byte_en[4*5 +: 4] = 4'hF;
        step();
        idle_inputs();
        checks++; if (err_multi !== 1'b1) begin errors++; $display("FAIL multi_flag got %0b want 1", err_multi); end
        checks++; if (err_count !== 1) begin errors++; $display("FAIL multi_count got %0d want 1", err_count); end
        checks++; if (lat_of(0) !== 3) begin errors++; $display("FAIL multi_max_latency got %0d want 3", lat_of(0)); end
        clear = 1'b1;
        mon_write[4] = 1'b1;
        mon_request_ready[4] = 1'b1;
        step();
        idle_inputs();
        checks++; if (err_multi !== 1'b0) begin errors++; $display("FAIL clear_multi got %0b want 0", err_multi); end
        checks++; if (err_flags !== '0) begin errors++; $display("FAIL clear_flags got %0h want 0", err_flags); end
        checks++; if (err_count !== '0) begin errors++; $display("FAIL clear_count got %0d want 0", err_count); end
        checks++; if (max_latency !== '0) begin errors++; $display("FAIL clear_max_latency got %0h want 0", max_latency); end
        checks++; if (occ_of(0) !== 1) begin errors++; $display("FAIL clear_outstanding got %0d want 1", occ_of(0)); end
    endtask

    task automatic test_saturation();
        do_reset();
        mon_write[4] = 1'b1;
        mon_request_ready[4] = 1'b1;
        repeat (CNT_MAX + 5) step();
        idle_inputs();
        checks++; if (err_count !== CNT_W'(CNT_MAX)) begin errors++; $display("FAIL sat_count got %0d want %0d", err_count, CNT_MAX); end
    endtask

    task automatic test_random();
        logic [5*MN-1:0]     e_flags;
        logic [OCC_W*MN-1:0] e_occ;
        logic [TS_W*MN-1:0]  e_lat;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < MN; i++) begin
                if (m_pend[i] && $urandom_range(0, 3) != 0) begin
                    mon_request_ready[i] = ($urandom_range(0, 1) == 0);
                end else begin
                    mon_read[i]          = ($urandom_range(0, 5) == 0);
                    mon_write[i]         = ($urandom_range(0, 11) == 0);
                    mon_request_ready[i] = ($urandom_range(0, 1) == 0);
                    mon_address[32*i +: 32] = 32'($urandom_range(0, 3)) << 2;
                    mon_byte_en[4*i +: 4]   = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'hF;
                end
                mon_read_data_valid[i] = ($urandom_range(0, 4) == 0);
                mon_resp_ready[i]      = ($urandom_range(0, 3) != 0);
            end
            clear = ($urandom_range(0, 63) == 0);
            step();
            for (int i = 0; i < MN; i++) begin
                e_flags[5*i +: 5]         = m_flags[i];
                e_occ[OCC_W*i +: OCC_W]   = OCC_W'(q[i].size());
                e_lat[TS_W*i +: TS_W]     = TS_W'(m_maxlat[i]);
            end
            checks++; if (err_flags !== e_flags) begin errors++; $display("FAIL rnd_flags cyc %0d got %0h want %0h", c, err_flags, e_flags); end
            checks++; if (err_multi !== m_multi) begin errors++; $display("FAIL rnd_multi cyc %0d got %0b want %0b", c, err_multi, m_multi); end
            checks++; if (err_count !== CNT_W'(m_count)) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, err_count, m_count); end
            checks++; if (outstanding !== e_occ) begin errors++; $display("FAIL rnd_outstanding cyc %0d got %0h want %0h", c, outstanding, e_occ); end
            checks++; if (max_latency !== e_lat) begin errors++; $display("FAIL rnd_max_latency cyc %0d got %0h want %0h", c, max_latency, e_lat); end
        end
        idle_inputs();
    endtask

    initial begin
        rest = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_read_latency();
        test_overflow();
        test_underflow();
        test_timeout();
        test_hold_conflict();
        test_multi_clear();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
